// File: rtl/reg_writeback_scoreboard_pkg.sv
// Shared types and sizing for the register writeback scoreboard.
// Counter width sets the per-register in-flight write limit.
package reg_writeback_scoreboard_pkg;

  localparam int NUM_REGS    = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int CNT_W       = 3;
  localparam int MAX_PENDING = (1 << CNT_W) - 1;
  localparam int TOT_W       = REG_ADDR_W + CNT_W;

  typedef logic [CNT_W-1:0]      pend_cnt_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam pend_cnt_t CNT_MAX    = pend_cnt_t'(MAX_PENDING);
  localparam pend_cnt_t CNT_MAX_M1 = pend_cnt_t'(MAX_PENDING - 1);

endpackage

// File: rtl/reg_writeback_scoreboard_counter.sv
// Pending-write counter for one architectural register.
// Applies up to two increments and two decrements per cycle, clamping at zero.
module reg_writeback_scoreboard_counter
  import reg_writeback_scoreboard_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [1:0]            up,
  input  logic [1:0]            dn,
  output pend_cnt_t             count,
  output logic                  busy,
  output logic                  underflow,
  output logic signed [CNT_W:0] delta
);

  logic [CNT_W+1:0] sum;
  logic [CNT_W+1:0] dnExt;
  pend_cnt_t        nextCnt;

  // Net update; more commits than pending writes clamps to zero and flags it
  always_comb begin
    sum       = {2'b00, count} + {{CNT_W{1'b0}}, up};
    dnExt     = {{CNT_W{1'b0}}, dn};
    underflow = sum < dnExt;
    nextCnt   = underflow ? '0 : pend_cnt_t'(sum - dnExt);
    delta     = signed'({1'b0, nextCnt}) - signed'({1'b0, count});
  end

  assign busy = count != '0;

  // Counter state
  always_ff @(posedge clock_i) begin
    if (reset_i) count <= '0;
    else         count <= nextCnt;
  end

endmodule

// File: rtl/reg_writeback_scoreboard.sv
// Per-register in-flight write scoreboard for the dual-pipe issue path.
// Gates issue on counter saturation and answers four busy queries per cycle.
module reg_writeback_scoreboard
  import reg_writeback_scoreboard_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  issueEnA_i,
  input  logic                  issueEnB_i,
  input  logic [REG_ADDR_W-1:0] issueRegA_i,
  input  logic [REG_ADDR_W-1:0] issueRegB_i,
  output logic                  issueReadyA_o,
  output logic                  issueReadyB_o,
  input  logic                  wbEnA_i,
  input  logic                  wbEnB_i,
  input  logic [REG_ADDR_W-1:0] wbRegA_i,
  input  logic [REG_ADDR_W-1:0] wbRegB_i,
  input  logic [REG_ADDR_W-1:0] queryPA_i,
  input  logic [REG_ADDR_W-1:0] querySA_i,
  input  logic [REG_ADDR_W-1:0] queryPB_i,
  input  logic [REG_ADDR_W-1:0] querySB_i,
  output logic                  busyPA_o,
  output logic                  busySA_o,
  output logic                  busyPB_o,
  output logic                  busySB_o,
  output logic [TOT_W-1:0]      pendingTotal_o,
  output logic                  idle_o,
  output logic                  errUnderflow_o
);

  pend_cnt_t             cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   busyVec;
  logic [NUM_REGS-1:0]   uflowVec;
  logic signed [CNT_W:0] delta [NUM_REGS];
  logic [TOT_W-1:0]      deltaSum;
  logic                  incA;
  logic                  incB;
  logic                  sameIssue;

  assign sameIssue = issueRegA_i == issueRegB_i;

  assign issueReadyA_o = cnt[issueRegA_i] != CNT_MAX;

  assign incA = issueEnA_i & issueReadyA_o;

  assign issueReadyB_o =
    !((cnt[issueRegB_i] == CNT_MAX) ||
      (incA && sameIssue &&
       (cnt[issueRegB_i] == CNT_MAX_M1)));

  assign incB = issueEnB_i & issueReadyB_o;

  for (genvar r = 0; r < NUM_REGS; r++) begin : gCnt
    logic hitIA, hitIB, hitWA, hitWB;
    logic [1:0] up, dn;

    assign hitIA = incA    && (issueRegA_i == REG_ADDR_W'(r));
    assign hitIB = incB    && (issueRegB_i == REG_ADDR_W'(r));
    assign hitWA = wbEnA_i && (wbRegA_i    == REG_ADDR_W'(r));
    assign hitWB = wbEnB_i && (wbRegB_i    == REG_ADDR_W'(r));
    assign up    = {1'b0, hitIA} + {1'b0, hitIB};
    assign dn    = {1'b0, hitWA} + {1'b0, hitWB};

    reg_writeback_scoreboard_counter uCnt (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .up        (up),
      .dn        (dn),
      .count     (cnt[r]),
      .busy      (busyVec[r]),
      .underflow (uflowVec[r]),
      .delta     (delta[r])
    );
  end

  assign busyPA_o = busyVec[queryPA_i];
  assign busySA_o = busyVec[querySA_i];
  assign busyPB_o = busyVec[queryPB_i];
  assign busySB_o = busyVec[querySB_i];

  // Net applied change across all registers, sign-extended to total width
  always_comb begin
    deltaSum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      deltaSum = deltaSum +
        {{(TOT_W-CNT_W-1){delta[i][CNT_W]}}, delta[i]};
    end
  end

  assign idle_o = pendingTotal_o == '0;

  // Running total of outstanding writes and sticky underflow flag
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pendingTotal_o <= '0;
      errUnderflow_o <= 1'b0;
    end else begin
      pendingTotal_o <= pendingTotal_o + deltaSum;
      errUnderflow_o <= errUnderflow_o | (|uflowVec);
    end
  end

endmodule

// File: tb/tb_reg_writeback_scoreboard.sv
// Randomized and directed bench for the register writeback scoreboard.
// Reference keeps plain integer counts per register and derives all outputs.
module tb_reg_writeback_scoreboard;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       issueEnA_i, issueEnB_i;
  logic [4:0] issueRegA_i, issueRegB_i;
  logic       issueReadyA_o, issueReadyB_o;
  logic       wbEnA_i, wbEnB_i;
  logic [4:0] wbRegA_i, wbRegB_i;
  logic [4:0] queryPA_i, querySA_i, queryPB_i, querySB_i;
  logic       busyPA_o, busySA_o, busyPB_o, busySB_o;
  logic [7:0] pendingTotal_o;
  logic       idle_o;
  logic       errUnderflow_o;

  int checks   = 0;
  int failures = 0;
  int mCnt [32];
  int mErr;

  reg_writeback_scoreboard dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .issueEnA_i     (issueEnA_i),
    .issueEnB_i     (issueEnB_i),
    .issueRegA_i    (issueRegA_i),
    .issueRegB_i    (issueRegB_i),
    .issueReadyA_o  (issueReadyA_o),
    .issueReadyB_o  (issueReadyB_o),
    .wbEnA_i        (wbEnA_i),
    .wbEnB_i        (wbEnB_i),
    .wbRegA_i       (wbRegA_i),
    .wbRegB_i       (wbRegB_i),
    .queryPA_i      (queryPA_i),
    .querySA_i      (querySA_i),
    .queryPB_i      (queryPB_i),
    .querySB_i      (querySB_i),
    .busyPA_o       (busyPA_o),
    .busySA_o       (busySA_o),
    .busyPB_o       (busyPB_o),
    .busySB_o       (busySB_o),
    .pendingTotal_o (pendingTotal_o),
    .idle_o         (idle_o),
    .errUnderflow_o (errUnderflow_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic setIn(bit ea, int ra, bit eb, int rb,
                       bit wa, int wra, bit wb, int wrb);
    issueEnA_i  = ea;
    issueRegA_i = 5'(ra);
    issueEnB_i  = eb;
    issueRegB_i = 5'(rb);
    wbEnA_i     = wa;
    wbRegA_i    = 5'(wra);
    wbEnB_i     = wb;
    wbRegB_i    = 5'(wrb);
  endtask

  task automatic setQ(int pa, int sa, int pb, int sb);
    queryPA_i = 5'(pa);
    querySA_i = 5'(sa);
    queryPB_i = 5'(pb);
    querySB_i = 5'(sb);
  endtask

  // Check everything against the model, then advance one clock.
  task automatic cycle();
    int ra, rb, tot, n;
    int nx [32];
    bit rdyA, rdyB, incA, incB;
    #1;
    ra   = int'(issueRegA_i);
    rb   = int'(issueRegB_i);
    rdyA = mCnt[ra] != 7;
    rdyB = !(mCnt[rb] == 7 ||
             (issueEnA_i && rdyA && ra == rb && mCnt[rb] == 6));
    incA = issueEnA_i && rdyA;
    incB = issueEnB_i && rdyB;
    tot  = 0;
    foreach (mCnt[i]) tot += mCnt[i];
    checkVal("readyA", issueReadyA_o, rdyA);
    checkVal("readyB", issueReadyB_o, rdyB);
    checkVal("busyPA", busyPA_o, mCnt[queryPA_i] != 0);
    checkVal("busySA", busySA_o, mCnt[querySA_i] != 0);
    checkVal("busyPB", busyPB_o, mCnt[queryPB_i] != 0);
    checkVal("busySB", busySB_o, mCnt[querySB_i] != 0);
    checkVal("total", pendingTotal_o, tot);
    checkVal("idle", idle_o, tot == 0);
    checkVal("err", errUnderflow_o, mErr);
    for (int r = 0; r < 32; r++) begin
      n = mCnt[r];
      if (incA && ra == r) n++;
      if (incB && rb == r) n++;
      if (wbEnA_i && int'(wbRegA_i) == r) n--;
      if (wbEnB_i && int'(wbRegB_i) == r) n--;
      if (n < 0) begin
        n    = 0;
        mErr = 1;
      end
      nx[r] = n;
    end
    @(posedge clock_i);
    if (reset_i) begin
      foreach (mCnt[i]) mCnt[i] = 0;
      mErr = 0;
    end else begin
      foreach (mCnt[i]) mCnt[i] = nx[i];
    end
    @(negedge clock_i);
  endtask

  task automatic idleCycles(int k);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    foreach (mCnt[i]) mCnt[i] = 0;
    mErr    = 0;
    reset_i = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    setQ(3, 7, 1, 4);
    @(negedge clock_i);
    cycle();
    cycle();
    reset_i = 1'b0;

    // reset values
    #1;
    checkVal("rst_idle", idle_o, 1);
    checkVal("rst_total", pendingTotal_o, 0);

    // single issue then writeback on r3
    setIn(1, 3, 0, 0, 0, 0, 0, 0);
    cycle();
    idleCycles(3);
    setIn(0, 0, 0, 0, 1, 3, 0, 0);
    cycle();
    idleCycles(1);

    // dual issue and staggered writeback on r7
    setIn(1, 7, 1, 7, 0, 0, 0, 0);
    cycle();
    #1 checkVal("r7_total2", pendingTotal_o, 2);
    setIn(0, 0, 0, 0, 1, 7, 0, 0);
    cycle();
    setIn(0, 0, 0, 0, 0, 0, 1, 7);
    cycle();
    idleCycles(1);

    // saturate r1
    for (int i = 0; i < 7; i++) begin
      setIn(1, 1, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    setIn(1, 1, 1, 2, 1, 1, 0, 0);
    #1;
    checkVal("sat_readyA", issueReadyA_o, 0);
    checkVal("sat_readyB_r2", issueReadyB_o, 1);
    cycle();
    setIn(1, 1, 0, 0, 0, 0, 0, 0);
    #1 checkVal("sat_readyA_back", issueReadyA_o, 1);
    cycle();

    // r4 at six, dual issue
    for (int i = 0; i < 6; i++) begin
      setIn(1, 4, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    setIn(1, 4, 1, 4, 0, 0, 0, 0);
    #1;
    checkVal("r4_readyA", issueReadyA_o, 1);
    checkVal("r4_readyB", issueReadyB_o, 0);
    cycle();
    setIn(1, 4, 0, 0, 0, 0, 0, 0);
    #1 checkVal("r4_full", issueReadyA_o, 0);
    cycle();

    // underflow on empty r9
    setIn(0, 0, 0, 0, 1, 9, 0, 0);
    cycle();
    setQ(9, 9, 9, 9);
    #1 checkVal("uflow_set", errUnderflow_o, 1);
    idleCycles(3);

    // reset, then issue and writeback same register same cycle
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    setQ(5, 5, 5, 5);
    setIn(1, 5, 0, 0, 0, 0, 0, 0);
    cycle();
    setIn(1, 5, 0, 0, 0, 0, 1, 5);
    cycle();
    #1;
    checkVal("r5_busy", busyPA_o, 1);
    checkVal("r5_noerr", errUnderflow_o, 0);
    setIn(1, 6, 1, 8, 0, 0, 0, 0);
    cycle();

    // reset mid-flight with activity on the inputs
    reset_i = 1'b1;
    setIn(1, 10, 1, 11, 1, 5, 0, 0);
    cycle();
    reset_i = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("midrst_idle", idle_o, 1);
    checkVal("midrst_busy", busyPA_o, 0);
    cycle();

    // random traffic concentrated on a few registers
    for (int c = 0; c < 3000; c++) begin
      reset_i = ($urandom_range(0, 79) == 0);
      setIn($urandom_range(0, 9) < 6, $urandom_range(0, 5),
            $urandom_range(0, 9) < 6, $urandom_range(0, 5),
            $urandom_range(0, 9) < 4, $urandom_range(0, 5),
            $urandom_range(0, 9) < 4, $urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) setIn(
            $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 31));
      setQ($urandom_range(0, 5), $urandom_range(0, 5),
           $urandom_range(0, 5), $urandom_range(0, 31));
      cycle();
    end
    reset_i = 1'b0;
    idleCycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback_scoreboard.md
# reg_writeback_scoreboard

Register-release side of the dual-pipe issue path. Counts in-flight register writes per architectural register: incremented when pipe A/B dispatches a primary-operand write, decremented when pipe A/B writeback commits that register. Answers four busy queries per cycle, so the dependency-resolution stage stalls on true completion instead of a fixed cycle timeout. Sits beside dispatch; fed by the execute/writeback stages of both pipes.

## Interface
- NUM_REGS, 32, architectural registers tracked
- REG_ADDR_W, 5, register index width
- CNT_W, 3, per-register pending-write counter width; MAX = 2^CNT_W-1 = 7
- clock_i  in  1  single clock, all state on rising edge
- reset_i  in  1  synchronous, active-high reset
- issueEnA_i, issueEnB_i  in  1  pipe dispatches an instruction with primary write
- issueRegA_i, issueRegB_i  in  REG_ADDR_W  destination register of that write
- issueReadyA_o, issueReadyB_o  out  1  issue accepted this cycle if high (combinational)
- wbEnA_i, wbEnB_i  in  1  pipe writeback commits a register this cycle
- wbRegA_i, wbRegB_i  in  REG_ADDR_W  register committed
- queryPA_i, querySA_i, queryPB_i, querySB_i  in  REG_ADDR_W  operand registers to check (secondary operand callers pass low 5 bits)
- busyPA_o, busySA_o, busyPB_o, busySB_o  out  1  queried register has count != 0 (combinational from registered state)
- pendingTotal_o  out  REG_ADDR_W+CNT_W  registered sum of all counters
- idle_o  out  1  pendingTotal_o == 0
- errUnderflow_o  out  1  sticky: writeback to a register with nothing pending

## Operation
- Accept: incA = issueEnA_i & issueReadyA_o; incB = issueEnB_i & issueReadyB_o.
- issueReadyA_o = count[issueRegA_i] != MAX.
- issueReadyB_o = count[issueRegB_i] + (incA & issueRegA_i==issueRegB_i) < MAX+... defined as: false if count[issueRegB_i] == MAX, or if incA, same register and count == MAX-1. Otherwise true. Ready does not depend on same-cycle writebacks (conservative).
- Per register r, each cycle: up = incA(r)+incB(r) (0..2), dn = decA(r)+decB(r) (0..2), dec only when wbEn high and register matches.
- next = count + up - dn computed at CNT_W+2 bits; if negative: next = 0, errUnderflow_o set. Never exceeds MAX given ready rules.
- Same register on both writebacks: dn = 2. Issue and writeback same register same cycle: net applied, no error if count+up >= dn.
- pendingTotal_o updated with same net delta summed across all registers (underflow-clamped amounts excluded).
- errUnderflow_o cleared only by reset.

## Timing
- Reset (sync, reset_i high at edge): all counters 0, pendingTotal_o 0, errUnderflow_o 0; hence busy*_o 0, idle_o 1, issueReady*_o 1. Reset overrides same-cycle issues/writebacks.
- Issue at edge N: busy visible from cycle N+1. No bypass: writeback at edge N clears busy only from N+1.
- Query ports purely combinational off counter state; zero-cycle latency.
- issueReady*_o combinational from inputs and state; dispatch must not advance an instruction whose ready is low that cycle.
- Counter saturation (7 pending) blocks further issue to that register until a writeback lands; other registers unaffected.

## Structure
- Shared package: NUM_REGS, REG_ADDR_W, CNT_W, MAX_PENDING constant, pend_cnt_t typedef.
- Sub-module scoreboard_counter: one instance per register; inputs up[1:0], dn[1:0], outputs count, busy, underflow pulse. Top level does decode, ready logic, query muxes, total accumulator, sticky error.

## Test plan
- Reset, issue A to r3 at cycle 1 -> busyPA_o (query r3) low in cycle 1, high cycle 2; wbA r3 cycle 5 -> busy low cycle 6, idle_o 1.
- Issue A and B both to r7 same cycle -> count 2, pendingTotal_o 2; single wbA r7 -> still busy; wbB r7 next -> clear.
- Seven issues to r1 -> issueReadyA_o low for r1, r2 still ready; one writeback -> ready returns next cycle.
- Count r4 = 6, issue A and B to r4 same cycle -> A accepted, issueReadyB_o low, count 7.
- wbA r9 with count 0 -> errUnderflow_o high next cycle, count stays 0, persists until reset_i.
- Issue A r5 and wbB r5 same cycle with count 1 -> count stays 1, no error; reset mid-flight -> all outputs at reset values next cycle.
